// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid-buffered pipeline stage with flush and statistics.
//
// Ports:
//   clk, reset            - single clock; asynchronous active-high reset
//   flush                 - synchronous squash of all held entries
//   in_valid / in_ready   - upstream handshake (in_ready is registered)
//   in_data / in_ctrl     - upstream payload and control bundle
//   out_valid / out_ready - downstream handshake
//   out_data / out_ctrl   - presented payload / control (ctrl is zero when not valid)
//   occupancy             - number of held entries (0..2)
//   stall_cnt, bubble_cnt, flush_cnt - saturating statistics counters
module pipe_skid_stage #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_hs;
    logic              out_hs;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // Main register is out_data/out_ctrl itself; skid holds the second entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            occupancy  <= 2'd0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            // Statistics observe the cycle's handshake signals and survive flush.
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!out_valid && out_ready && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);

            if (flush) begin
                // Flush wins over any handshake; a same-cycle input is dropped.
                state     <= EMPTY;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_ctrl  <= '0;
                skid_data <= '0;
                skid_ctrl <= '0;
                occupancy <= 2'd0;
            end else begin
                case (state)
                    EMPTY: begin
                        // Also raises in_ready on the first edge after reset.
                        in_ready <= 1'b1;
                        if (in_hs) begin
                            out_data  <= in_data;
                            out_ctrl  <= in_ctrl;
                            out_valid <= 1'b1;
                            occupancy <= 2'd1;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_hs && out_hs) begin
                            out_data <= in_data;
                            out_ctrl <= in_ctrl;
                        end else if (in_hs) begin
                            skid_data <= in_data;
                            skid_ctrl <= in_ctrl;
                            in_ready  <= 1'b0;
                            occupancy <= 2'd2;
                            state     <= FULL;
                        end else if (out_hs) begin
                            // Clear ctrl so the bubble presents as a NOP.
                            out_valid <= 1'b0;
                            out_ctrl  <= '0;
                            occupancy <= 2'd0;
                            state     <= EMPTY;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only the output side can move.
                        if (out_hs) begin
                            out_data  <= skid_data;
                            out_ctrl  <= skid_ctrl;
                            in_ready  <= 1'b1;
                            occupancy <= 2'd1;
                            state     <= ONE;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_ctrl  <= '0;
                        occupancy <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule
